// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - shared widths, weight index map and sample type for the DNN input feeder
package dnn_pkg;

  localparam int X_W       = 7;
  localparam int W_W       = 5;
  localparam int N_WEIGHTS = 24;

  localparam int W04_IDX = 0;
  localparam int W05_IDX = 1;
  localparam int W06_IDX = 2;
  localparam int W07_IDX = 3;
  localparam int W14_IDX = 4;
  localparam int W15_IDX = 5;
  localparam int W16_IDX = 6;
  localparam int W17_IDX = 7;
  localparam int W24_IDX = 8;
  localparam int W25_IDX = 9;
  localparam int W26_IDX = 10;
  localparam int W27_IDX = 11;
  localparam int W34_IDX = 12;
  localparam int W35_IDX = 13;
  localparam int W36_IDX = 14;
  localparam int W37_IDX = 15;
  localparam int W48_IDX = 16;
  localparam int W58_IDX = 17;
  localparam int W68_IDX = 18;
  localparam int W78_IDX = 19;
  localparam int W49_IDX = 20;
  localparam int W59_IDX = 21;
  localparam int W69_IDX = 22;
  localparam int W79_IDX = 23;

  // Member order puts x0 in the low bits, matching the packed s_x layout.
  typedef struct packed {
    logic signed [X_W-1:0] x3;
    logic signed [X_W-1:0] x2;
    logic signed [X_W-1:0] x1;
    logic signed [X_W-1:0] x0;
  } sample_t;

endpackage

// File: rtl/dnn_in_feeder_if.sv
// rtl/dnn_in_feeder_if.sv - sample stream and weight write bus into the DNN input feeder
interface dnn_in_feeder_if;
  import dnn_pkg::*;

  logic               s_valid;
  logic               s_ready;
  logic [4*X_W-1:0]   s_x;
  logic               wr_en;
  logic [4:0]         wr_addr;
  logic [W_W-1:0]     wr_data;
  logic               wr_commit;

  modport master (
    output s_valid, s_x, wr_en, wr_addr, wr_data, wr_commit,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_x, wr_en, wr_addr, wr_data, wr_commit,
    output s_ready
  );

endinterface

// File: rtl/dnn_sample_fifo.sv
// rtl/dnn_sample_fifo.sv - synchronous FIFO with registered full/empty, no pass-through
module dnn_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/dnn_in_feeder.sv
// rtl/dnn_in_feeder.sv - paced sample issue and weight bank for the MAC stage
// DNN_FEEDER_WSHADOW_EN selects a shadow weight bank with deferred commit.
module dnn_in_feeder
  import dnn_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int ISSUE_INTERVAL = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  dnn_in_feeder_if.slave              bus,
  output logic                        in_ready,
  output logic signed [X_W-1:0]       x0,
  output logic signed [X_W-1:0]       x1,
  output logic signed [X_W-1:0]       x2,
  output logic signed [X_W-1:0]       x3,
  output logic [N_WEIGHTS*W_W-1:0]    w_bus,
  output logic                        commit_pending,
  output logic [15:0]                 issued_cnt
);

  localparam int CW = $clog2(ISSUE_INTERVAL);

  logic                          fifo_full, fifo_empty;
  sample_t                       fifo_head;
  logic                          issue_fire, wr_hit;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          in_ready_q;
  sample_t                       sample_q, sample_d;
  logic [15:0]                   issued_cnt_q, issued_cnt_d;
  logic [N_WEIGHTS-1:0][W_W-1:0] active_q, active_d;

  dnn_sample_fifo #(.DEPTH(DEPTH), .WIDTH(4*X_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.s_valid),
    .pop_i   (issue_fire),
    .wdata_i (bus.s_x),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.s_ready = !fifo_full;
  assign issue_fire  = !fifo_empty && (cnt_q == '0);
  assign wr_hit      = bus.wr_en && (bus.wr_addr < 5'(N_WEIGHTS));

  always_comb begin
    cnt_d        = cnt_q;
    sample_d     = sample_q;
    issued_cnt_d = issued_cnt_q;
    if (issue_fire) begin
      cnt_d        = CW'(ISSUE_INTERVAL - 1);
      sample_d     = fifo_head;
      issued_cnt_d = issued_cnt_q + 16'd1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

`ifdef DNN_FEEDER_WSHADOW_EN
  logic [N_WEIGHTS-1:0][W_W-1:0] shadow_q, shadow_d;
  logic                          pending_q, pending_d;

  // The copy takes the shadow including this cycle's write, and never lands on an issue edge.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (wr_hit) shadow_d[bus.wr_addr] = bus.wr_data;
    if (pending_q && !issue_fire) begin
      active_d  = shadow_d;
      pending_d = 1'b0;
    end else if (bus.wr_commit) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign commit_pending = pending_q;
`else
  logic unused_commit;
  assign unused_commit = bus.wr_commit;

  always_comb begin
    active_d = active_q;
    if (wr_hit) active_d[bus.wr_addr] = bus.wr_data;
  end

  assign commit_pending = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      in_ready_q   <= 1'b0;
      sample_q     <= '0;
      issued_cnt_q <= '0;
      active_q     <= '0;
    end else begin
      cnt_q        <= cnt_d;
      in_ready_q   <= issue_fire;
      sample_q     <= sample_d;
      issued_cnt_q <= issued_cnt_d;
      active_q     <= active_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign x0         = sample_q.x0;
  assign x1         = sample_q.x1;
  assign x2         = sample_q.x2;
  assign x3         = sample_q.x3;
  assign w_bus      = active_q;
  assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_dnn_in_feeder.sv
// tb/tb_dnn_in_feeder.sv - directed self-checking bench for dnn_in_feeder
module tb_dnn_in_feeder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_ready;
  logic signed [6:0] x0, x1, x2, x3;
  logic [119:0] w_bus;
  logic         commit_pending;
  logic [15:0]  issued_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  dnn_in_feeder_if bus();

  dnn_in_feeder #(.DEPTH(4), .ISSUE_INTERVAL(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .in_ready       (in_ready),
    .x0             (x0),
    .x1             (x1),
    .x2             (x2),
    .x3             (x3),
    .w_bus          (w_bus),
    .commit_pending (commit_pending),
    .issued_cnt     (issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [4:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    step();
    bus.wr_en   = 1'b0;
  endtask

  logic [119:0] wexp;
  logic [27:0]  sx [6];
  logic [27:0]  s_single;
  int           exp_issued;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  pushed, nissued, last, pulses;
    bit  saw_full, accept;

    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_x = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_commit = 1'b0;
    step(); step();
    rst = 1'b0;

    check("rst_in_ready", 128'(in_ready), 128'(1'b0));
    check("rst_s_ready", 128'(bus.s_ready), 128'(1'b1));
    check("rst_x", 128'({x3, x2, x1, x0}), 128'(28'h0));
    check("rst_w_bus", 128'(w_bus), 128'(120'h0));
    check("rst_pending", 128'(commit_pending), 128'(1'b0));
    check("rst_issued", 128'(issued_cnt), 128'(16'h0));

    wexp = '0;
    for (int a = 0; a < 24; a++) begin
      wr(5'(a), 5'd1);
      wexp[5*a +: 5] = 5'd1;
    end
`ifdef DNN_FEEDER_WSHADOW_EN
    check("shadow_hidden", 128'(w_bus), 128'(120'h0));
    bus.wr_commit = 1'b1;
    step();
    bus.wr_commit = 1'b0;
    check("commit_set", 128'(commit_pending), 128'(1'b1));
    step();
    check("commit_clear", 128'(commit_pending), 128'(1'b0));
`endif
    check("weights_all_one", 128'(w_bus), 128'(wexp));

    wr(5'd25, 5'd9);
`ifdef DNN_FEEDER_WSHADOW_EN
    bus.wr_commit = 1'b1; step(); bus.wr_commit = 1'b0; step();
`endif
    check("addr_guard", 128'(w_bus), 128'(wexp));

    // Single sample x = (3, -2, 5, -64)
    s_single = {7'h40, 7'h05, 7'h7E, 7'h03};
    bus.s_valid = 1'b1; bus.s_x = s_single;
    step();
    bus.s_valid = 1'b0;
    check("single_decision_cycle", 128'(in_ready), 128'(1'b0));
    step();
    check("single_in_ready", 128'(in_ready), 128'(1'b1));
    check("single_x", 128'({x3, x2, x1, x0}), 128'(s_single));
    check("single_issued", 128'(issued_cnt), 128'(16'd1));
    step();
    check("single_pulse_width", 128'(in_ready), 128'(1'b0));
    check("single_x_hold", 128'({x3, x2, x1, x0}), 128'(s_single));
    exp_issued = 1;
    step(); step(); step();

`ifdef DNN_FEEDER_WSHADOW_EN
    bus.s_valid = 1'b1; bus.s_x = s_single;
    step();
    bus.s_valid = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd16; bus.wr_data = 5'h19; bus.wr_commit = 1'b1;
    step();
    bus.wr_en = 1'b0; bus.wr_commit = 1'b0;
    check("cdi_in_ready", 128'(in_ready), 128'(1'b1));
    check("cdi_w48_held", 128'(w_bus[84:80]), 128'(5'd1));
    check("cdi_pending", 128'(commit_pending), 128'(1'b1));
    step();
    check("cdi_w48_new", 128'(w_bus[84:80]), 128'(5'h19));
    check("cdi_pending_clear", 128'(commit_pending), 128'(1'b0));
    exp_issued++;
    step(); step(); step();
`else
    bus.wr_commit = 1'b1;
    step();
    bus.wr_commit = 1'b0;
    check("no_shadow_pending", 128'(commit_pending), 128'(1'b0));
    wr(5'd16, 5'h19);
    check("no_shadow_w48", 128'(w_bus[84:80]), 128'(5'h19));
`endif
    wexp[84:80] = 5'h19;
    check("w_bus_after_w48", 128'(w_bus), 128'(wexp));

    // Burst of 6 into a 4-deep FIFO
    for (int i = 0; i < 6; i++)
      sx[i] = {7'(i * 3 + 20), 7'(i + 40), 7'(100 - i), 7'(i + 1)};
    pushed = 0; nissued = 0; last = -1; saw_full = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (in_ready) begin
        if (nissued < 6) check("burst_x", 128'({x3, x2, x1, x0}), 128'(sx[nissued]));
        if (nissued > 0) check("burst_gap", 128'(cyc - last), 128'(4));
        last = cyc;
        nissued++;
      end
      if (!bus.s_ready) saw_full = 1'b1;
      bus.s_valid = (pushed < 6);
      bus.s_x     = (pushed < 6) ? sx[pushed] : '0;
      accept      = bus.s_valid && bus.s_ready;
      step();
      if (accept) pushed++;
    end
    bus.s_valid = 1'b0;
    exp_issued += 6;
    check("burst_pushed", 128'(pushed), 128'(6));
    check("burst_issued_n", 128'(nissued), 128'(6));
    check("burst_saw_full", 128'(saw_full), 128'(1'b1));
    check("burst_issued_cnt", 128'(issued_cnt), 128'(exp_issued));

    // Reset with 3 samples queued
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1; bus.s_x = sx[i];
      step();
    end
    bus.s_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_in_ready", 128'(in_ready), 128'(1'b0));
    check("mid_rst_s_ready", 128'(bus.s_ready), 128'(1'b1));
    check("mid_rst_x", 128'({x3, x2, x1, x0}), 128'(28'h0));
    check("mid_rst_w_bus", 128'(w_bus), 128'(120'h0));
    check("mid_rst_issued", 128'(issued_cnt), 128'(16'h0));
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (in_ready) pulses++;
      step();
    end
    check("mid_rst_no_issue", 128'(pulses), 128'(0));

    // issued_cnt wrap
    force dut.issued_cnt_q = 16'hFFFF;
    step();
    release dut.issued_cnt_q;
    step();
    check("wrap_preload", 128'(issued_cnt), 128'(16'hFFFF));
    bus.s_valid = 1'b1; bus.s_x = sx[5];
    step();
    bus.s_valid = 1'b0;
    step();
    check("wrap_in_ready", 128'(in_ready), 128'(1'b1));
    check("wrap_issued", 128'(issued_cnt), 128'(16'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
